// File: rtl/bram_portb_arbiter.sv
// BRAM port-B arbiter: VGA fetch has priority; IO gets a forced grant after MAX_WAIT
// waiting cycles when BRAM_ARB_STARVE_GUARD_EN is defined (otherwise strict VGA priority).
module bram_portb_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_gnt,
   output logic              io_rvalid,
   output logic [DATA_W-1:0] io_rdata,
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] data_b,
   output logic              we_b,
   input  logic [DATA_W-1:0] q_b
);
   typedef enum logic [1:0] {S_IDLE, S_VGA, S_IO, S_FORCE} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_IO} owner_t;

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   state_t            state_q, state_d;
   owner_t            rd_owner_q, rd_owner_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] vga_rdata_q, io_rdata_q;
   logic              force_io;

`ifdef BRAM_ARB_STARVE_GUARD_EN
   // wait_cnt_q equals the number of cycles IO has already been refused
   assign force_io = io_req && (state_q == S_VGA) && (wait_cnt_q == WAIT_MAX);
`else
   assign force_io = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rd_owner_q  <= OWN_NONE;
         wait_cnt_q  <= '0;
         vga_rdata_q <= '0;
         io_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         rd_owner_q  <= rd_owner_d;
         wait_cnt_q  <= wait_cnt_d;
         vga_rdata_q <= vga_rdata;
         io_rdata_q  <= io_rdata;
      end
   end

   // state_d is also the grant decision for the current cycle
   always_comb begin
      state_d = S_IDLE;
      if (rst)
         state_d = S_IDLE;
      else if (force_io)
         state_d = S_FORCE;
      else if (vga_req)
         state_d = S_VGA;
      else if (io_req)
         state_d = S_IO;
   end

   always_comb begin
      vga_gnt = (state_d == S_VGA);
      io_gnt  = (state_d == S_IO) || (state_d == S_FORCE);
      we_b    = io_gnt & io_we;
      data_b  = io_wdata;
      addr_b  = '0;
      if (vga_gnt)
         addr_b = vga_addr;
      else if (io_gnt)
         addr_b = io_addr;
   end

   always_comb begin
      rd_owner_d = OWN_NONE;
      if (vga_gnt)
         rd_owner_d = OWN_VGA;
      else if (io_gnt && !io_we)
         rd_owner_d = OWN_IO;

      wait_cnt_d = wait_cnt_q;
      if (!io_req || io_gnt)
         wait_cnt_d = '0;
      else if (wait_cnt_q != WAIT_MAX)
         wait_cnt_d = wait_cnt_q + 4'd1;

      // q_b is forwarded in the return cycle and captured so it holds afterwards
      vga_rvalid = !rst && (rd_owner_q == OWN_VGA);
      io_rvalid  = !rst && (rd_owner_q == OWN_IO);
      vga_rdata  = vga_rvalid ? q_b : vga_rdata_q;
      io_rdata   = io_rvalid ? q_b : io_rdata_q;
   end
endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Directed bench for bram_portb_arbiter: vector table plus starvation and mid-read reset sequences,
// with a small 1-cycle-latency BRAM model on port B.
module tb_bram_portb_arbiter;
   logic        clk = 1'b0;
   logic        rst, vga_req, io_req, io_we;
   logic [15:0] vga_addr, io_addr, io_wdata;
   logic        vga_gnt, vga_rvalid, io_gnt, io_rvalid, we_b;
   logic [15:0] vga_rdata, io_rdata, addr_b, data_b;
   logic [15:0] q_b = 16'h0000;
   logic [15:0] mem [0:255];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bram_portb_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
      .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
      .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
   );

   // BRAM model: preload known words while rst is high, registered read
   always @(posedge clk) begin
      if (rst) begin
         mem[8'h00] <= 16'h0000;
         mem[8'h10] <= 16'hBEEF;
         mem[8'h30] <= 16'h1234;
      end else if (we_b) begin
         mem[addr_b[7:0]] <= data_b;
      end
      q_b <= mem[addr_b[7:0]];
   end

   typedef struct {
      logic        rst, vreq;
      logic [15:0] vaddr;
      logic        ireq, iwe;
      logic [15:0] iaddr, iwd;
      logic        vgnt, ignt, we;
      logic [15:0] addr, data;
      logic        vrv, irv;
      logic [15:0] vrd, ird;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic vr, input logic [15:0] va,
                        input logic ir, input logic iw, input logic [15:0] ia, input logic [15:0] iwd);
      rst = r; vga_req = vr; vga_addr = va;
      io_req = ir; io_we = iw; io_addr = ia; io_wdata = iwd;
   endtask

   initial begin
      logic io_pending;
      logic exp_ig;

      //          rst vreq vaddr     ireq iwe iaddr     iwd       vgnt ignt we  addr_b    data_b    vrv irv vrdata    irdata
      vecs[0]  = '{1'b1, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0020, 16'h00A5, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5, 1'b0, 1'b0, 16'h0000, 16'h0000};
      vecs[1]  = '{1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
      vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h00A5, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h00A5, 1'b1, 1'b0, 16'hBEEF, 16'h0000};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'h00A5};
      vecs[5]  = '{1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h00A5};
      vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 16'h00A5};
      vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'h00A5};
      vecs[8]  = '{1'b0, 1'b1, 16'h0030, 1'b1, 1'b1, 16'h0040, 16'h0077, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0077, 1'b0, 1'b0, 16'hBEEF, 16'h00A5};
      vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h0077, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0077, 1'b1, 1'b0, 16'h1234, 16'h00A5};
      vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h00A5};
      vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'h0077};
      vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0077};

      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (3) @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].rst, vecs[i].vreq, vecs[i].vaddr, vecs[i].ireq, vecs[i].iwe, vecs[i].iaddr, vecs[i].iwd);
         #1;
         chk($sformatf("v%0d vga_gnt", i),    32'(vga_gnt),    32'(vecs[i].vgnt));
         chk($sformatf("v%0d io_gnt", i),     32'(io_gnt),     32'(vecs[i].ignt));
         chk($sformatf("v%0d we_b", i),       32'(we_b),       32'(vecs[i].we));
         chk($sformatf("v%0d addr_b", i),     32'(addr_b),     32'(vecs[i].addr));
         chk($sformatf("v%0d data_b", i),     32'(data_b),     32'(vecs[i].data));
         chk($sformatf("v%0d vga_rvalid", i), 32'(vga_rvalid), 32'(vecs[i].vrv));
         chk($sformatf("v%0d io_rvalid", i),  32'(io_rvalid),  32'(vecs[i].irv));
         chk($sformatf("v%0d vga_rdata", i),  32'(vga_rdata),  32'(vecs[i].vrd));
         chk($sformatf("v%0d io_rdata", i),   32'(io_rdata),   32'(vecs[i].ird));
         $display("[TB] vec %0d: vga_gnt=%b io_gnt=%b addr_b=%h vga_rdata=%h io_rdata=%h",
                  i, vga_gnt, io_gnt, addr_b, vga_rdata, io_rdata);
         @(negedge clk);
      end

      // Starvation: VGA already owns the port, IO request rises at cycle 0
      drive(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      io_pending = 1'b1;
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 1'b1, 16'h0010, io_pending, 1'b1, 16'h0050, 16'h005A);
         #1;
`ifdef BRAM_ARB_STARVE_GUARD_EN
         exp_ig = (c == 4);
`else
         exp_ig = 1'b0;
`endif
         chk($sformatf("starve c%0d io_gnt", c),  32'(io_gnt),  32'(exp_ig));
         chk($sformatf("starve c%0d vga_gnt", c), 32'(vga_gnt), 32'(!exp_ig));
         $display("[TB] starve cycle %0d: vga_gnt=%b io_gnt=%b", c, vga_gnt, io_gnt);
         if (io_gnt) io_pending = 1'b0;
         @(negedge clk);
      end
      // A waiting IO request is served as soon as VGA lets go
      drive(1'b0, 1'b0, 16'h0, io_pending, 1'b1, 16'h0050, 16'h005A);
      #1;
      chk("release io_gnt", 32'(io_gnt), 32'(io_pending));
      chk("release vga_rvalid", 32'(vga_rvalid), 32'd1);
      chk("release vga_rdata", 32'(vga_rdata), 32'h0000BEEF);
      $display("[TB] release: io_gnt=%b vga_rvalid=%b", io_gnt, vga_rvalid);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);

      // Reset one cycle after a VGA read grant, with IO waiting
      drive(1'b0, 1'b1, 16'h0030, 1'b1, 1'b0, 16'h0020, 16'h0);
      #1;
      chk("rstmid grant vga_gnt", 32'(vga_gnt), 32'd1);
      $display("[TB] rstmid grant: vga_gnt=%b addr_b=%h", vga_gnt, addr_b);
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h0030, 1'b1, 1'b0, 16'h0020, 16'h0);
      #1;
      chk("rstmid vga_rvalid", 32'(vga_rvalid), 32'd0);
      chk("rstmid vga_rdata", 32'(vga_rdata), 32'h0000BEEF);
      chk("rstmid vga_gnt", 32'(vga_gnt), 32'd0);
      chk("rstmid io_gnt", 32'(io_gnt), 32'd0);
      $display("[TB] rstmid in reset: vga_rvalid=%b vga_rdata=%h", vga_rvalid, vga_rdata);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      #1;
      chk("rstmid after vga_rvalid", 32'(vga_rvalid), 32'd0);
      chk("rstmid after io_rvalid", 32'(io_rvalid), 32'd0);
      chk("rstmid after vga_rdata", 32'(vga_rdata), 32'd0);
      chk("rstmid after wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
      $display("[TB] rstmid after release: vga_rvalid=%b wait_cnt=%0d", vga_rvalid, dut.wait_cnt_q);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
